task_dispatcher: RTL and testbench



---
 rtl/task_dispatcher.sv | 249 ++++++++++++++++++++++++
 tb/tb_task_dispatcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatcher.sv
// Task dispatcher: walks header + instruction frames in program memory and streams them to the core bus.
// Optional macro SCHED_PERF_CNT_EN enables the wait_cycles / task_cnt performance counters.
module task_dispatcher #(
    parameter int DATA_DEPTH  = 1024,
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 16,
    parameter int CORE_NUM    = 16,
    parameter int IFNUM_W     = 6,
    localparam int ADDR_W     = $clog2(DATA_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [WORD_W-1:0]   prog_wdata,
    input  logic                start,
    input  logic [CORE_NUM-1:0] core_busy,
    input  logic                msg_ready,
    output logic                msg_valid,
    output logic [WORD_W-1:0]   msg_data,
    output logic                mask_load,
    output logic                r0_load,
    output logic                if_load,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         wait_cycles,
    output logic [15:0]         task_cnt
);

    localparam int FW_LOG = $clog2(FRAME_WORDS);
    // Wide enough to hold a task end address far past the memory without wrapping.
    localparam int PTR_W  = ADDR_W + IFNUM_W + FW_LOG + 2;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DATA_DEPTH);
    localparam logic [PTR_W-1:0] FRAME_P = PTR_W'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_WAIT, S_SEND, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_MASK, K_R0, K_IF} kind_t;

    state_t              r_state, w_state_nxt;
    logic [WORD_W-1:0]   r_mem [DATA_DEPTH];
    logic [WORD_W-1:0]   r_rdata;
    logic [PTR_W-1:0]    r_ptr, r_rd_ptr, r_end;
    logic [IFNUM_W-1:0]  r_ifnum;
    logic [1:0]          r_fence;
    logic [CORE_NUM-1:0] r_mask, r_prev_mask;
    logic                r_prev_rel, r_done, r_err;
    logic                r_inflight;
    kind_t               r_inflight_kind;
    logic [WORD_W-1:0]   r_fq_data [2];
    kind_t               r_fq_kind [2];
    logic [1:0]          r_fq_cnt;

    logic                w_start, w_clear, w_pop, w_more, w_issue;
    logic                w_task_end, w_ovf_end, w_fetch_ovf, w_wr_idx;
    logic [1:0]          w_fq_cnt_nxt;
    logic [PTR_W-1:0]    w_off;
    kind_t               w_issue_kind;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);

    assign w_clear = ((r_mask & core_busy) == '0)
                  && (r_fence != 2'd1 || core_busy == '0)
                  && (!r_prev_rel || (r_prev_mask & core_busy) == '0);

    // Two-entry output queue fed by the 1-cycle memory; credits count the read in flight.
    assign w_pop        = (r_fq_cnt != 2'd0) && msg_ready;
    assign w_fq_cnt_nxt = r_fq_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_wr_idx     = (r_fq_cnt == 2'd2) || (r_fq_cnt == 2'd1 && !w_pop);
    assign w_more       = (r_rd_ptr < r_end) && (r_rd_ptr < DEPTH_P);
    assign w_issue      = (r_state == S_SEND) && w_more && (w_fq_cnt_nxt < 2'd2);
    assign w_task_end   = (r_state == S_SEND) && (r_rd_ptr >= r_end) && (w_fq_cnt_nxt == 2'd0);
    assign w_ovf_end    = (r_state == S_SEND) && (r_rd_ptr < r_end) && (r_rd_ptr >= DEPTH_P)
                       && (w_fq_cnt_nxt == 2'd0);
    assign w_fetch_ovf  = (r_ptr + PTR_W'(1)) >= DEPTH_P;

    assign w_off        = r_rd_ptr - r_ptr;
    assign w_issue_kind = (w_off == PTR_W'(1)) ? K_MASK : (w_off < FRAME_P) ? K_R0 : K_IF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_state_nxt = S_FETCH0;
            S_FETCH0:       w_state_nxt = w_fetch_ovf ? S_DONE : S_FETCH1;
            S_FETCH1:       w_state_nxt = S_FETCH2;
            S_FETCH2:       w_state_nxt = (r_rdata[CORE_NUM-1:0] == '0) ? S_DONE : S_WAIT;
            S_WAIT:         if (w_clear) w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_task_end) begin
                    w_state_nxt = S_FETCH0;
                end else if (w_ovf_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en   = w_issue;
        w_rd_addr = r_rd_ptr[ADDR_W-1:0];
        case (r_state)
            S_FETCH0: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_ptr[ADDR_W-1:0];
            end
            S_FETCH1: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_ptr[ADDR_W-1:0] + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    // Loading is only allowed while no program is being walked.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE || r_state == S_DONE)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
        if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_rd_ptr    <= '0;
            r_end       <= '0;
            r_ifnum     <= '0;
            r_fence     <= '0;
            r_mask      <= '0;
            r_prev_mask <= '0;
            r_prev_rel  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_inflight  <= 1'b0;
            r_fq_cnt    <= '0;
        end else begin
            r_inflight <= w_issue;
            r_fq_cnt   <= w_fq_cnt_nxt;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_ptr       <= '0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_prev_mask <= '0;
                        r_prev_rel  <= 1'b0;
                    end
                end
                S_FETCH0: begin
                    if (w_fetch_ovf) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                S_FETCH1: begin
                    r_ifnum <= r_rdata[IFNUM_W-1:0];
                    r_fence <= r_rdata[7:6];
                end
                S_FETCH2: begin
                    r_mask   <= r_rdata[CORE_NUM-1:0];
                    r_rd_ptr <= r_ptr + PTR_W'(1);
                    r_end    <= r_ptr + ((PTR_W'(r_ifnum) + PTR_W'(1)) << FW_LOG);
                    if (r_rdata[CORE_NUM-1:0] == '0) begin
                        r_done <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_task_end) begin
                        r_ptr       <= r_end;
                        r_prev_mask <= r_mask;
                        r_prev_rel  <= (r_fence == 2'd2);
                    end else if (w_ovf_end) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_inflight_kind <= w_issue_kind;
        end
        if (w_pop) begin
            r_fq_data[0] <= r_fq_data[1];
            r_fq_kind[0] <= r_fq_kind[1];
        end
        if (r_inflight) begin
            r_fq_data[w_wr_idx] <= r_rdata;
            r_fq_kind[w_wr_idx] <= r_inflight_kind;
        end
    end

    assign msg_valid = (r_fq_cnt != 2'd0);
    assign msg_data  = msg_valid ? r_fq_data[0] : '0;
    assign mask_load = msg_valid && (r_fq_kind[0] == K_MASK);
    assign r0_load   = msg_valid && (r_fq_kind[0] == K_R0);
    assign if_load   = msg_valid && (r_fq_kind[0] == K_IF);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = r_done;
    assign err       = r_err;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_wait_cycles;
    logic [15:0] r_task_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_wait_cycles <= '0;
            r_task_cnt    <= '0;
        end else begin
            if (r_state == S_WAIT && !w_clear) begin
                r_wait_cycles <= r_wait_cycles + 32'd1;
            end
            if (w_task_end) begin
                r_task_cnt <= r_task_cnt + 16'd1;
            end
        end
    end

    assign wait_cycles = r_wait_cycles;
    assign task_cnt    = r_task_cnt;
`else
    assign wait_cycles = '0;
    assign task_cnt    = '0;
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: directed scenarios plus randomized programs and backpressure,
// checked against a queue-based reference walk of the program image.
module tb_task_dispatcher;

    localparam int DEPTH = 64;
    localparam int FW    = 16;
    localparam int LIMIT = 3000;
`ifdef SCHED_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, prog_we, start, msg_ready;
    logic [5:0]  prog_addr;
    logic [15:0] prog_wdata, core_busy;
    logic        msg_valid, mask_load, r0_load, if_load, busy, done, err;
    logic [15:0] msg_data;
    logic [31:0] wait_cycles;
    logic [15:0] task_cnt;

    task_dispatcher #(
        .DATA_DEPTH(DEPTH), .WORD_W(16), .FRAME_WORDS(FW), .CORE_NUM(16), .IFNUM_W(6)
    ) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .core_busy(core_busy), .msg_ready(msg_ready),
        .msg_valid(msg_valid), .msg_data(msg_data), .mask_load(mask_load), .r0_load(r0_load),
        .if_load(if_load), .busy(busy), .done(done), .err(err),
        .wait_cycles(wait_cycles), .task_cnt(task_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec, n_fail, cyc;
    bit          mon_on, prev_stall;
    logic [2:0]  mon_strb, prev_strb;
    logic [15:0] prev_data;
    logic [17:0] cap[$];
    int          cap_cyc[$];
    logic [17:0] exp_q[$];
    int          exp_tasks;
    bit          exp_err;
    logic [15:0] img [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bus monitor: strobe legality, hold-while-stalled, and capture of every transfer.
    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            mon_strb = {if_load, r0_load, mask_load};
            chk("strobe_onehot", $countones(mon_strb), msg_valid ? 1 : 0);
            if (prev_stall)
                chk("hold_stable", {msg_valid, mon_strb, msg_data}, {1'b1, prev_strb, prev_data});
            if (msg_valid && msg_ready) begin
                cap.push_back({mon_strb[2] ? 2'd2 : mon_strb[1] ? 2'd1 : 2'd0, msg_data});
                cap_cyc.push_back(cyc);
            end
            prev_stall = msg_valid && !msg_ready && !reset;
            prev_strb  = mon_strb;
            prev_data  = msg_data;
        end
    end

    // Reference: walk tasks by the record rules, emit {kind, word}; kind 0 mask, 1 r0, 2 instr.
    function automatic void model();
        int p, n;
        exp_q.delete();
        exp_tasks = 0;
        exp_err   = 1'b0;
        p = 0;
        while (1) begin
            if (p + 1 >= DEPTH) begin exp_err = 1'b1; return; end
            if (img[p+1] == 16'h0) return;
            n = int'(img[p][5:0]);
            for (int a = p + 1; a < p + FW * (1 + n); a++) begin
                if (a >= DEPTH) begin exp_err = 1'b1; return; end
                exp_q.push_back({(a == p + 1) ? 2'd0 : (a < p + FW) ? 2'd1 : 2'd2, img[a]});
            end
            exp_tasks++;
            p += FW * (1 + n);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_img();
        for (int a = 0; a < DEPTH; a++) begin
            prog_we = 1'b1; prog_addr = 6'(a); prog_wdata = img[a];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) img[a] = 16'($urandom);
    endtask

    task automatic build_single();
        fill_random();
        img[0] = 16'h0001; img[1] = 16'h0003; img[2] = 16'h00FF;
        for (int a = 3; a < 16; a++) img[a] = 16'(16'h0100 + a);
        for (int a = 16; a < 32; a++) img[a] = 16'(16'hA000 + (a - 16));
        img[32] = 16'h0000; img[33] = 16'h0000;
    endtask

    task automatic kick();
        cap.delete(); cap_cyc.delete();
        model();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rnd);
        int t = 0;
        while (!done && t < LIMIT) begin
            msg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            t++;
        end
        msg_ready = 1'b1;
        chk({tag, "_timeout"}, 32'(t < LIMIT), 1);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), cap[i], exp_q[i]);
        chk({tag, "_flags"}, {done, busy, err}, {1'b1, 1'b0, exp_err});
        chk({tag, "_tasks"}, task_cnt, PERF ? exp_tasks : 0);
    endtask

    task automatic stall_cycles(input string tag, input int n, input int expected_caps);
        for (int i = 0; i < n; i++) tick();
        chk({tag, "_stalled"}, {busy, 8'(cap.size())}, {1'b1, 8'(expected_caps)});
    endtask

    initial begin
        int t, n_if;
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        core_busy = '0; msg_ready = 1'b1;
        n_vec = 0; n_fail = 0; cyc = 0; mon_on = 1'b0; prev_stall = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        mon_on = 1'b1;

        chk("rst_ctrl", {msg_valid, mask_load, r0_load, if_load, busy, done, err}, 0);
        chk("rst_data", msg_data, 0);
        chk("rst_wait", wait_cycles, 0);
        chk("rst_tasks", task_cnt, 0);

        // Single task, full-rate streaming.
        build_single();
        load_img();
        kick();
        wait_done("single", 1'b0);
        compare("single");
        chk("single_n", cap.size(), 31);
        if (cap.size() == 31) chk("single_rate", cap_cyc[30] - cap_cyc[0], 30);

        // Core collision; a program write during the stall must be ignored.
        core_busy = 16'h0002;
        kick();
        for (int i = 0; i < 15; i++) begin
            if (i == 5) begin prog_we = 1'b1; prog_addr = 6'd16; prog_wdata = 16'hDEAD; end
            tick();
            prog_we = 1'b0;
        end
        chk("coll_stalled", {busy, 8'(cap.size())}, {1'b1, 8'd0});
        core_busy = '0;
        wait_done("coll", 1'b0);
        compare("coll");
        if (cap.size() > 0) chk("coll_first", cap[0], {2'd0, 16'h0003});
        chk("coll_wait", PERF ? 32'(wait_cycles >= 10) : wait_cycles, PERF ? 1 : 0);

        // Acquire fence waits for every core to go idle.
        fill_random();
        img[0] = 16'h0040; img[1] = 16'h0001; img[16] = 16'h0000; img[17] = 16'h0000;
        load_img();
        core_busy = 16'h8000;
        kick();
        stall_cycles("acq", 15, 0);
        core_busy = '0;
        wait_done("acq", 1'b0);
        compare("acq");

        // Release fence holds the next task until the released cores are idle.
        fill_random();
        img[0] = 16'h0080; img[1] = 16'h0010; img[16] = 16'h0000; img[17] = 16'h0001;
        img[32] = 16'h0000; img[33] = 16'h0000;
        load_img();
        kick();
        t = 0;
        while (cap.size() < 15 && t < 200) begin tick(); t++; end
        chk("rel_first_task", 32'(t < 200), 1);
        core_busy = 16'h0010;
        stall_cycles("rel", 15, 15);
        core_busy = '0;
        wait_done("rel", 1'b0);
        compare("rel");

        // Address overflow on the first instruction frame of the task at 48.
        fill_random();
        img[0]  = 16'h0000; img[1]  = 16'h0001;
        img[16] = 16'h0000; img[17] = 16'h0002;
        img[32] = 16'h00C0; img[33] = 16'h0008;
        img[48] = 16'h0002; img[49] = 16'h0004;
        load_img();
        kick();
        wait_done("ovf", 1'b1);
        compare("ovf");
        n_if = 0;
        foreach (cap[i]) if (cap[i][17:16] == 2'd2) n_if++;
        chk("ovf_no_if", {err, 8'(n_if), 8'(cap.size())}, {1'b1, 8'd0, 8'd60});

        // Randomized programs under random backpressure.
        for (int it = 0; it < 6; it++) begin
            int p, n;
            fill_random();
            p = 0;
            while (p < DEPTH) begin
                n = $urandom_range(0, 2);
                img[p] = {8'($urandom), 2'($urandom_range(0, 3)), 6'(n)};
                if ($urandom_range(0, 5) == 0) img[p+1] = 16'h0000;
                if (img[p+1] == 16'h0000) break;
                p += FW * (1 + n);
            end
            load_img();
            kick();
            wait_done($sformatf("rand%0d", it), 1'b1);
            compare($sformatf("rand%0d", it));
        end

        // Reset in the middle of the instruction frame, then replay from address 0.
        build_single();
        load_img();
        kick();
        t = 0;
        while (cap.size() < 20 && t < 200) begin tick(); t++; end
        chk("mid_reached", 32'(t < 200), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_ctrl", {msg_valid, mask_load, r0_load, if_load, busy, done, err}, 0);
        chk("mid_rst_data", msg_data, 0);
        chk("mid_rst_cnt", {wait_cycles, task_cnt}, 0);
        reset = 1'b0;
        tick();
        kick();
        wait_done("replay", 1'b1);
        compare("replay");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
